// File: rtl/sha256_pkg.sv
// Shared constants, state encoding and helpers for the SHA-256 message padder.
package sha256_pkg;

  localparam int BLOCK_BITS     = 512;
  localparam int BLOCK_BYTES    = 64;
  localparam int LEN_FIELD_BITS = 64;
  localparam int LEN_FIT_MAX    = 55;
  localparam int POS_W          = $clog2(BLOCK_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_PAD,
    ST_EMIT,
    ST_LENBLK
  } pad_state_t;

  // Message length in bytes -> 64-bit bit count for the trailing length field.
  function automatic logic [LEN_FIELD_BITS-1:0] bit_length(input logic [31:0] len_bytes);
    return {29'd0, len_bytes, 3'b000};
  endfunction

endpackage

// File: rtl/sha256_msg_padder_if.sv
// Byte-in / block-out handshake bundle of the SHA-256 message padder.
interface sha256_msg_padder_if #(
  parameter int MAX_MSG_BYTES = 1024,
  parameter int LEN_W         = $clog2(MAX_MSG_BYTES + 1)
);

  logic             start;
  logic [LEN_W-1:0] msg_len;
  logic             err;
  logic             busy;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_ready;
  logic             block_valid;
  logic             block_ready;
  logic [511:0]     block_data;
  logic             block_last;

  // master: message source plus block consumer; slave: the padder itself.
  modport master (
    output start, msg_len, byte_valid, byte_data, block_ready,
    input  err, busy, byte_ready, block_valid, block_data, block_last
  );

  modport slave (
    input  start, msg_len, byte_valid, byte_data, block_ready,
    output err, busy, byte_ready, block_valid, block_data, block_last
  );

endinterface

// File: rtl/sha256_pad_buffer.sv
// 512-bit block buffer: byte write at index, clear, 0x80 marker and length insert.
module sha256_pad_buffer
  import sha256_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      wr_en,
  input  logic                      mark_en,
  input  logic [POS_W-1:0]          wr_idx,
  input  logic [7:0]                wr_byte,
  input  logic                      len_en,
  input  logic [LEN_FIELD_BITS-1:0] len_bits,
  output logic [BLOCK_BITS-1:0]     data
);

  logic [BLOCK_BITS-1:0] data_q;
  logic [BLOCK_BITS-1:0] data_d;

  // Byte i occupies bits [511-8i -: 8], so its lsb is at 504-8i.
  function automatic logic [8:0] byte_lsb(input logic [POS_W-1:0] idx);
    return 9'(BLOCK_BITS - 8) - {idx, 3'b000};
  endfunction

  always_comb begin
    data_d = clear ? '0 : data_q;
    if (wr_en)   data_d[byte_lsb(wr_idx) +: 8] = wr_byte;
    if (mark_en) data_d[byte_lsb(wr_idx) +: 8] = 8'h80;
    if (len_en)  data_d[LEN_FIELD_BITS-1:0]    = len_bits;
  end

  always_ff @(posedge clock) begin
    if (reset) data_q <= '0;
    else       data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/sha256_msg_padder.sv
// Streaming SHA-256 padder: bytes in, padded 512-bit blocks out, arbitrary length.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int MAX_MSG_BYTES = 1024,
  parameter int LEN_W         = $clog2(MAX_MSG_BYTES + 1)
) (
  input logic                clock,
  input logic                reset,
  sha256_msg_padder_if.slave bus
);

  pad_state_t       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             last_q, last_d;
  logic             pend_q, pend_d;
  logic             pad_done_q, pad_done_d;
  logic             err_q, err_d;

  logic             byte_ready_c;
  logic             buf_clear, buf_wr, buf_mark, buf_len_wr;
  logic [BLOCK_BITS-1:0] buf_data;

  sha256_pad_buffer u_buf (
    .clock    (clock),
    .reset    (reset),
    .clear    (buf_clear),
    .wr_en    (buf_wr),
    .mark_en  (buf_mark),
    .wr_idx   (pos_q),
    .wr_byte  (bus.byte_data),
    .len_en   (buf_len_wr),
    .len_bits (bit_length(32'(len_q))),
    .data     (buf_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      rem_q      <= '0;
      pos_q      <= '0;
      last_q     <= 1'b0;
      pend_q     <= 1'b0;
      pad_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      rem_q      <= rem_d;
      pos_q      <= pos_d;
      last_q     <= last_d;
      pend_q     <= pend_d;
      pad_done_q <= pad_done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    rem_d        = rem_q;
    pos_d        = pos_q;
    last_d       = last_q;
    pend_d       = pend_q;
    pad_done_d   = pad_done_q;
    err_d        = 1'b0;
    byte_ready_c = 1'b0;
    buf_clear    = 1'b0;
    buf_wr       = 1'b0;
    buf_mark     = 1'b0;
    buf_len_wr   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.msg_len > LEN_W'(MAX_MSG_BYTES)) begin
            err_d = 1'b1;
          end else begin
            len_d      = bus.msg_len;
            rem_d      = bus.msg_len;
            pos_d      = '0;
            last_d     = 1'b0;
            pend_d     = 1'b0;
            pad_done_d = 1'b0;
            buf_clear  = 1'b1;
            state_d    = ST_FILL;
          end
        end
      end

      ST_FILL: begin
        byte_ready_c = (rem_q != '0);
        if (rem_q == '0) begin
          state_d = ST_PAD;
        end else if (bus.byte_valid) begin
          buf_wr = 1'b1;
          pos_d  = pos_q + POS_W'(1);
          rem_d  = rem_q - LEN_W'(1);
          // A full block takes priority; pos wraps to 0 through the 6-bit counter.
          if (pos_q == POS_W'(BLOCK_BYTES - 1)) state_d = ST_EMIT;
          else if (rem_q == LEN_W'(1))          state_d = ST_PAD;
        end
      end

      ST_PAD: begin
        buf_mark   = 1'b1;
        pad_done_d = 1'b1;
        if (pos_q <= POS_W'(LEN_FIT_MAX)) begin
          buf_len_wr = 1'b1;
          last_d     = 1'b1;
        end else begin
          pend_d = 1'b1;
        end
        state_d = ST_EMIT;
      end

      ST_EMIT: begin
        if (bus.block_ready) begin
          if (last_q) begin
            last_d  = 1'b0;
            state_d = ST_IDLE;
          end else if (pend_q) begin
            pend_d  = 1'b0;
            state_d = ST_LENBLK;
          end else if (rem_q != '0) begin
            buf_clear = 1'b1;
            state_d   = ST_FILL;
          end else begin
            // Length was a multiple of 64: marker and length go in a fresh block.
            buf_clear = 1'b1;
            pos_d     = '0;
            state_d   = ST_PAD;
          end
        end
      end

      ST_LENBLK: begin
        buf_clear  = 1'b1;
        buf_len_wr = 1'b1;
        last_d     = 1'b1;
        state_d    = ST_EMIT;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.byte_ready  = byte_ready_c;
  assign bus.block_valid = (state_q == ST_EMIT);
  assign bus.block_last  = (state_q == ST_EMIT) && last_q;
  assign bus.block_data  = buf_data;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.err         = err_q;

endmodule

// File: doc/sha256_msg_padder.md
# sha256_msg_padder

Streaming SHA-256 message padder. Accepts a message of run-time length (0..MAX_MSG_BYTES bytes) one byte per handshake and emits the fully padded message as a sequence of 512-bit blocks. Appends the 0x80 marker, zero fill and 64-bit big-endian bit length, and spills into an extra block when the length field does not fit. Sits between the message byte source and the SHA-256 compression core, and replaces the single-block, fixed-length padder.

## Interface
Parameters:
- MAX_MSG_BYTES, 1024: largest accepted message length in bytes.
- LEN_W, $clog2(MAX_MSG_BYTES+1): width of msg_len (derived; do not override).

Ports:
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  begin a message; samples msg_len; honoured only in IDLE.
- msg_len  in  LEN_W  message length in bytes.
- err  out  1  one-cycle pulse: start seen with msg_len > MAX_MSG_BYTES.
- busy  out  1  high in any state other than IDLE.
- byte_valid  in  1  byte_data is valid.
- byte_data  in  8  message byte.
- byte_ready  out  1  padder accepts a byte this cycle.
- block_valid  out  1  block_data is valid.
- block_ready  in  1  consumer accepts the block.
- block_data  out  512  padded block; byte i of the block sits at bits [511-8i -: 8].
- block_last  out  1  qualifies block_valid: final block of the message.

## Operation
- States: IDLE, FILL, PAD, EMIT, LENBLK.
- IDLE:
  - On start with msg_len <= MAX_MSG_BYTES: latch len, clear buffer, pos=0, rem=len, go to FILL.
  - On start with msg_len > MAX_MSG_BYTES: pulse err and stay in IDLE.
- FILL:
  - byte_ready=1 while rem>0.
  - On handshake: buffer byte[pos]=byte_data, pos++, rem--.
  - When pos reaches 64: go to EMIT (non-last); pos wraps to 0.
  - When rem=0 and pos<64: go to PAD.
- PAD (one cycle, no handshake):
  - Write byte[pos]=0x80.
  - If pos<=55: write bits [63:0]=len*8 (zero-extended to 64 bits), flag last, go to EMIT.
  - Otherwise: go to EMIT non-last, with pending length block.
- EMIT:
  - block_valid=1 and block_data=buffer, held stable until block_ready.
  - On accept after a non-last block with rem>0: clear buffer, go to FILL.
  - On accept with rem=0 and no pad yet written (length was a multiple of 64): clear buffer, pos=0, go to PAD.
  - On accept with a pending length block: go to LENBLK.
  - On accept of a last block: go to IDLE.
- LENBLK (one cycle): buffer = zeros with bits [63:0]=len*8, flag last, go to EMIT.
- Empty message (len=0): FILL passes straight to PAD; one block 0x80 00.. 00 is emitted, last.
- Block count per message = floor((len+8)/64)+1.
- start outside IDLE is ignored. byte_data presented while byte_ready=0 is not consumed.

## Timing
- Reset: IDLE, block_valid=0, block_last=0, block_data=0, byte_ready=0, busy=0, err=0; buffer cleared.
- Reset mid-message aborts immediately; no partial block is emitted afterwards.
- Byte handshake: accepted at the posedge where byte_valid&&byte_ready. Throughput is 1 byte/cycle in FILL.
- Block after the 64th byte: block_valid rises on the following cycle.
- Block after the final byte: 1 cycle of PAD, so block_valid rises 2 cycles after the last handshake.
- Length-only block: block_valid rises 2 cycles after the prior block is accepted (LENBLK then EMIT).
- byte_ready=0 in PAD, EMIT and LENBLK. The padder buffers no more than one block.
- block_last is valid only while block_valid=1; it is 0 otherwise.
- err is registered: it pulses the cycle after start.

## Structure
- Package sha256_pkg holds:
  - BLOCK_BITS=512, BLOCK_BYTES=64, LEN_FIELD_BITS=64, LEN_FIT_MAX=55;
  - the padder state enum.
- One sub-module: sha256_pad_buffer, a 512-bit register with byte-write at index, clear, 0x80 insert and length insert. The padder FSM drives it.

## Test plan
- len=3, bytes 61 62 63 -> one block 0x61626380 followed by zeros, bits[63:0]=0x18, block_last=1.
- len=0 -> one block 0x80 followed by zeros, length 0, last; exactly 2 cycles after start's FSM entry into FILL.
- len=55 -> one block: byte55=0x80, length 0x1B8, last. len=56 -> two blocks: the first has byte56=0x80 and is non-last; the second is all zero with length 0x1C0, last.
- len=64 -> two blocks: block 0 = 64 data bytes, non-last; block 1 = 0x80 followed by zeros, length 0x200, last. len=130 -> three blocks, the third carries 0x80 at byte 2 and length 0x410.
- Random block_ready backpressure and byte_valid gaps on len=200 -> block_data stable while stalled, no lost or duplicated bytes, 4 blocks.
- start with msg_len=MAX_MSG_BYTES+1 -> err pulse, busy stays 0. reset asserted mid-FILL -> all outputs at reset values next cycle; a new message then pads correctly.
